// File: rtl/hann_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hann_frame_ctrl
// Brief   : Hanning-window frame sequencer. Frames the sample stream, drives
//           the coefficient ROM address and emits windowed, tagged samples.
//           Optional macro HANN_ROUND_EN selects round-half-up scaling.
// Revision: 1.0  initial release
// ============================================================================
module hann_frame_ctrl #(
    parameter int FRAME_LEN = 512,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int                        c_PROD_W   = 2 * DATA_W + 1;
    localparam logic [ADDR_W-1:0]         c_LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic signed [c_PROD_W-1:0] c_RND     =
        {{(DATA_W + 1){1'b0}}, 1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                drain_q, drain_d;

    logic                s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic                s1_sof_q, s1_sof_d;
    logic                s1_eof_q, s1_eof_d;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_sof_q, out_sof_d;
    logic                out_eof_q, out_eof_d;
    logic                frame_done_q, frame_done_d;

    logic                w_abort;
    logic                w_accept;
    logic                w_last;
    logic signed [c_PROD_W-1:0] w_sample_ext;
    logic signed [c_PROD_W-1:0] w_coef_ext;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_prod_adj;
    logic [DATA_W-1:0]   w_scaled;
    logic                w_unused;

    // Abort only matters while a frame is in flight and beats any accept.
    always_comb begin
        w_abort  = abort && (state_q != ST_IDLE);
        w_accept = in_valid && (state_q == ST_RUN) && !abort;
        w_last   = (idx_q == c_LAST_IDX);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (w_last) begin
                        idx_d = '0;
                        if (!cont) begin
                            state_d = ST_DRAIN;
                            drain_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d = ST_IDLE;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                drain_d = 1'b0;
            end
        endcase
        if (w_abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            drain_d = 1'b0;
        end
    end

    // Stage 1 holds the sample while the ROM registers its coefficient.
    always_comb begin
        s1_valid_d = w_accept;
        s1_data_d  = w_accept ? in_data : s1_data_q;
        s1_sof_d   = w_accept && (idx_q == '0);
        s1_eof_d   = w_accept && w_last;
    end

    always_comb begin
        w_sample_ext = {{(DATA_W + 1){s1_data_q[DATA_W-1]}}, s1_data_q};
        w_coef_ext   = {{(DATA_W + 1){1'b0}}, rom_q};
        w_prod       = w_sample_ext * w_coef_ext;
`ifdef HANN_ROUND_EN
        w_prod_adj   = w_prod + c_RND;
`else
        w_prod_adj   = w_prod;
`endif
        w_scaled     = w_prod_adj[2*DATA_W-1:DATA_W];
        w_unused     = ^{w_prod_adj[c_PROD_W-1], w_prod_adj[DATA_W-1:0], c_RND};
    end

    always_comb begin
        out_valid_d  = s1_valid_q && !w_abort;
        out_data_d   = out_valid_d ? w_scaled : out_data_q;
        out_sof_d    = out_valid_d && s1_sof_q;
        out_eof_d    = out_valid_d && s1_eof_q;
        frame_done_d = out_valid_d && s1_eof_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            drain_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_sof_q     <= 1'b0;
            s1_eof_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drain_q      <= drain_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_sof_q     <= s1_sof_d;
            s1_eof_q     <= s1_eof_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == ST_RUN);
        rom_addr   = idx_q;
        busy       = (state_q != ST_IDLE);
        out_valid  = out_valid_q;
        out_data   = out_data_q;
        out_sof    = out_sof_q;
        out_eof    = out_eof_q;
        frame_done = frame_done_q;
    end

endmodule
`default_nettype wire
